apb_splitter: RTL and testbench

Registered, parametrised 1-to-N APB splitter between the core's APB initiator port and TGT_N APB targets. It replaces the fixed three-target combinational decoder with a base/mask address map. Each transfer is re-launched on the target side from registered request state, so no combinational path runs from initiator to target. It adds an unmapped-address error response and an optional per-transfer timeout that aborts a hung target.

---
 rtl/apb_splitter_pkg.sv | 29 ++
 rtl/apb_addr_decode.sv | 46 ++++
 rtl/apb_splitter.sv | 211 +++++++++++++++++++++
 tb/tb_apb_splitter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_splitter_pkg.sv
// -----------------------------------------------------------------------------
// apb_splitter_pkg
// Shared types for the registered 1-to-N APB splitter.
//   state_t   : splitter FSM states
//   apb_req_t : request captured from the initiator (addr holds the target offset)
//   apb_rsp_t : response returned to the initiator
// -----------------------------------------------------------------------------
package apb_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        T_SETUP  = 2'd1,
        T_ACCESS = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// -----------------------------------------------------------------------------
// apb_addr_decode
// Combinational base/mask address decoder.
//   addr   in  32     initiator address
//   hit    out TGT_N  one-hot target hit, lowest index wins on overlap
//   miss   out 1      no target matched
//   offset out 32     addr with the selected target's mask bits cleared
//                     (addr unchanged on a miss)
// -----------------------------------------------------------------------------
module apb_addr_decode #(
    parameter int unsigned               TGT_N    = 3,
    parameter logic [TGT_N-1:0][31:0]    TGT_BASE = {32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [TGT_N-1:0][31:0]    TGT_MASK = {32'hFC00_0000, 32'hFFFF_F000, 32'h8000_0000}
) (
    input  logic [31:0]      addr,
    output logic [TGT_N-1:0] hit,
    output logic             miss,
    output logic [31:0]      offset
);

    logic [TGT_N-1:0] raw_hit;

    genvar gi;
    generate
        for (gi = 0; gi < TGT_N; gi++) begin : g_match
            assign raw_hit[gi] = ((addr & TGT_MASK[gi]) == TGT_BASE[gi]);
        end
    endgenerate

    // Walk from the highest index down so the lowest matching index is the
    // last one written and therefore wins.
    always_comb begin
        hit    = '0;
        offset = addr;
        for (int k = TGT_N - 1; k >= 0; k--) begin
            if (raw_hit[k]) begin
                hit    = '0;
                hit[k] = 1'b1;
                offset = addr & ~TGT_MASK[k];
            end
        end
    end

    assign miss = ~|raw_hit;

endmodule

// File: rtl/apb_splitter.sv
// -----------------------------------------------------------------------------
// apb_splitter
// Registered 1-to-N APB splitter. The initiator request is captured in IDLE
// and re-launched on the target side from registers, so no combinational path
// runs from the initiator port to any target port. Unmapped addresses get an
// immediate error response.
//
// Optional feature macro: APB_SPLITTER_TIMEOUT_EN
//   When defined, a target that holds pready low for TIMEOUT_CYC access
//   cycles is abandoned and the initiator receives pslverr=1, prdata=0.
//   When undefined, T_ACCESS waits indefinitely and TIMEOUT_CYC is unused.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_psel/i_penable/i_pwrite           initiator request controls
//   i_paddr/i_pwdata/i_pwstrb           initiator request data
//   i_pready/i_pslverr/i_prdata         initiator response
//   t_psel [TGT_N]                      one-hot target select
//   t_penable/t_pwrite                  shared target controls
//   t_paddr/t_pwdata/t_pwstrb           shared registered target request
//   t_pready/t_pslverr [TGT_N]          per-target response
//   t_prdata [TGT_N*32]                 per-target read data, target k at [32k+:32]
// -----------------------------------------------------------------------------
module apb_splitter
    import apb_splitter_pkg::*;
#(
    parameter int unsigned               TGT_N       = 3,
    parameter logic [TGT_N-1:0][31:0]    TGT_BASE    = {32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [TGT_N-1:0][31:0]    TGT_MASK    = {32'hFC00_0000, 32'hFFFF_F000, 32'h8000_0000},
    parameter int unsigned               TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_psel,
    input  logic                 i_penable,
    input  logic                 i_pwrite,
    input  logic [31:0]          i_paddr,
    input  logic [31:0]          i_pwdata,
    input  logic [3:0]           i_pwstrb,
    output logic                 i_pready,
    output logic                 i_pslverr,
    output logic [31:0]          i_prdata,
    output logic [TGT_N-1:0]     t_psel,
    output logic                 t_penable,
    output logic                 t_pwrite,
    output logic [31:0]          t_paddr,
    output logic [31:0]          t_pwdata,
    output logic [3:0]           t_pwstrb,
    input  logic [TGT_N-1:0]     t_pready,
    input  logic [TGT_N-1:0]     t_pslverr,
    input  logic [TGT_N*32-1:0]  t_prdata
);

    // Capture happens on i_psel alone; the initiator's penable phase carries
    // no extra information for a registered re-launch.
    logic unused_penable;
    assign unused_penable = i_penable;

    state_t           state_reg, state_next;
    apb_req_t         req_reg, req_next;
    apb_rsp_t         rsp_reg, rsp_next;
    logic [TGT_N-1:0] sel_reg, sel_next;

`ifdef APB_SPLITTER_TIMEOUT_EN
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // ---------------------------------------------------------------- decode
    logic [TGT_N-1:0] dec_hit;
    logic             dec_miss;
    logic [31:0]      dec_offset;

    apb_addr_decode #(
        .TGT_N    (TGT_N),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .addr   (i_paddr),
        .hit    (dec_hit),
        .miss   (dec_miss),
        .offset (dec_offset)
    );

    // ------------------------------------------- selected target response mux
    // sel_reg is one-hot, so an AND-OR reduction picks the active target.
    logic [TGT_N-1:0]       tgt_ready_m;
    logic [TGT_N-1:0]       tgt_err_m;
    logic [TGT_N-1:0][31:0] tgt_rdata_m;

    genvar gi;
    generate
        for (gi = 0; gi < TGT_N; gi++) begin : g_rsp
            assign tgt_ready_m[gi] = sel_reg[gi] & t_pready[gi];
            assign tgt_err_m[gi]   = sel_reg[gi] & t_pslverr[gi];
            assign tgt_rdata_m[gi] = {32{sel_reg[gi]}} & t_prdata[32*gi +: 32];
        end
    endgenerate

    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < TGT_N; k++) begin
            sel_rdata = sel_rdata | tgt_rdata_m[k];
        end
    end

    assign sel_ready = |tgt_ready_m;
    assign sel_err   = |tgt_err_m;

    // ------------------------------------------------------------ next state
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        rsp_next   = rsp_reg;
        sel_next   = sel_reg;
`ifdef APB_SPLITTER_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_psel) begin
                    req_next.addr  = dec_offset;
                    req_next.write = i_pwrite;
                    req_next.wdata = i_pwdata;
                    req_next.wstrb = i_pwstrb;
                    sel_next       = dec_hit;
                    if (dec_miss) begin
                        rsp_next.rdata  = '0;
                        rsp_next.slverr = 1'b1;
                        state_next      = RESP;
                    end else begin
                        state_next = T_SETUP;
                    end
                end
            end
            T_SETUP: begin
`ifdef APB_SPLITTER_TIMEOUT_EN
                cnt_next   = '0;
`endif
                state_next = T_ACCESS;
            end
            T_ACCESS: begin
                if (sel_ready) begin
                    rsp_next.rdata  = sel_rdata;
                    rsp_next.slverr = sel_err;
                    state_next      = RESP;
`ifdef APB_SPLITTER_TIMEOUT_EN
                end else if (cnt_reg == CNT_LIMIT) begin
                    // Limit reached with pready still low: abandon the target.
                    rsp_next.rdata  = '0;
                    rsp_next.slverr = 1'b1;
                    state_next      = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
`endif
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            req_reg   <= '0;
            rsp_reg   <= '0;
            sel_reg   <= '0;
`ifdef APB_SPLITTER_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            rsp_reg   <= rsp_next;
            sel_reg   <= sel_next;
`ifdef APB_SPLITTER_TIMEOUT_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    // ---------------------------------------------------------------- outputs
    // All outputs are decoded from registers only.
    logic tgt_active;
    assign tgt_active = (state_reg == T_SETUP) || (state_reg == T_ACCESS);

    assign t_psel    = tgt_active ? sel_reg : '0;
    assign t_penable = (state_reg == T_ACCESS);
    assign t_pwrite  = req_reg.write;
    assign t_paddr   = req_reg.addr;
    assign t_pwdata  = req_reg.wdata;
    assign t_pwstrb  = req_reg.wstrb;

    assign i_pready  = (state_reg == RESP);
    assign i_pslverr = (state_reg == RESP) & rsp_reg.slverr;
    assign i_prdata  = rsp_reg.rdata;

endmodule

// File: tb/tb_apb_splitter.sv
module tb_apb_splitter;

    localparam int TGT_N = 3;
    localparam int NV    = 9;
    localparam int NEVER = 100000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_psel = 1'b0, i_penable = 1'b0, i_pwrite = 1'b0;
    logic [31:0]         i_paddr = '0, i_pwdata = '0;
    logic [3:0]          i_pwstrb = '0;
    logic                i_pready, i_pslverr;
    logic [31:0]         i_prdata;
    logic [TGT_N-1:0]    t_psel;
    logic                t_penable, t_pwrite;
    logic [31:0]         t_paddr, t_pwdata;
    logic [3:0]          t_pwstrb;
    logic [TGT_N-1:0]    t_pready, t_pslverr;
    logic [TGT_N*32-1:0] t_prdata;

    apb_splitter #(.TGT_N(TGT_N), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_psel(i_psel), .i_penable(i_penable), .i_pwrite(i_pwrite),
        .i_paddr(i_paddr), .i_pwdata(i_pwdata), .i_pwstrb(i_pwstrb),
        .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata),
        .t_psel(t_psel), .t_penable(t_penable), .t_pwrite(t_pwrite),
        .t_paddr(t_paddr), .t_pwdata(t_pwdata), .t_pwstrb(t_pwstrb),
        .t_pready(t_pready), .t_pslverr(t_pslverr), .t_prdata(t_prdata)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ target models
    int               wait_cfg [TGT_N];
    logic [31:0]      rdata_cfg [TGT_N];
    logic [TGT_N-1:0] err_cfg   = '0;
    logic [TGT_N-1:0] setup_rdy = '0;
    int               acc_cnt   = 0;

    always @(posedge clk) begin
        if (t_penable && !(|t_pready)) acc_cnt <= acc_cnt + 1;
        else                           acc_cnt <= 0;
    end

    genvar gi;
    for (gi = 0; gi < TGT_N; gi++) begin : g_tgt
        assign t_pready[gi]          = t_psel[gi] & ((setup_rdy[gi] & ~t_penable) |
                                                     (t_penable & (acc_cnt == wait_cfg[gi])));
        assign t_pslverr[gi]         = err_cfg[gi];
        assign t_prdata[32*gi +: 32] = rdata_cfg[gi];
    end

    // ------------------------------------------------------ checking
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rdata = '0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;
        logic        terr;
        logic [2:0]  exp_sel;
        logic [31:0] exp_paddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] paddr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.sel = v.exp_sel; e.paddr = v.exp_paddr; e.write = v.write;
        e.wdata = v.wdata; e.strb = v.strb; e.rdata = v.exp_rdata;
        e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
    endtask

    // Called at the start of cycle 0 (just after a rising edge).
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st);
        int   c;
        bit   done;
        exp_t e;
        i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr;
        i_paddr = addr; i_pwdata = wd; i_pwstrb = st;
        c = 0; done = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            if (c == 1 && sb.size() > 0) begin
                chk("setup_t_psel", t_psel, sb[0].sel);
                if (sb[0].sel != 3'b000) begin
                    chk("setup_t_paddr", t_paddr, sb[0].paddr);
                    chk("setup_t_pwrite", t_pwrite, sb[0].write);
                    chk("setup_t_penable", t_penable, 0);
                    if (sb[0].write) begin
                        chk("setup_t_pwdata", t_pwdata, sb[0].wdata);
                        chk("setup_t_pwstrb", t_pwstrb, sb[0].strb);
                    end
                end
            end
            if (i_pready) done = 1;
            else begin
                @(posedge clk); #1;
                i_penable = 1'b1;
                c++;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL xfer_bound addr=%h actual=no_pready required=pready", addr);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL scoreboard_empty actual=pready required=no_pready");
        end else begin
            e = sb.pop_front();
            chk("latency", c, e.lat);
            chk("i_prdata", i_prdata, e.rdata);
            chk("i_pslverr", i_pslverr, e.err);
            chk("resp_t_psel", t_psel, 0);
            last_rdata = e.rdata;
            $display("[TB] xfer addr=%h wr=%0d lat=%0d rdata=%h err=%0d", addr, wr, c, i_prdata, i_pslverr);
        end
        @(posedge clk); #1;
        i_psel = 1'b0; i_penable = 1'b0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_i_pready", i_pready, 0);
        chk("idle_i_pslverr", i_pslverr, 0);
        chk("idle_i_prdata_hold", i_prdata, last_rdata);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 0; k < TGT_N; k++) wait_cfg[k] = v.wt;
        err_cfg = v.terr ? '1 : '0;
        push_exp(v);
        xfer(v.addr, v.write, v.wdata, v.strb);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_t_psel"}, t_psel, 0);
        chk({tag, "_t_penable"}, t_penable, 0);
        chk({tag, "_t_paddr"}, t_paddr, 0);
        chk({tag, "_t_pwdata"}, t_pwdata, 0);
        chk({tag, "_t_pwstrb"}, t_pwstrb, 0);
        chk({tag, "_i_pready"}, i_pready, 0);
        chk({tag, "_i_prdata"}, i_prdata, 0);
        chk({tag, "_i_pslverr"}, i_pslverr, 0);
    endtask

    initial begin
        vec_t v;
        rdata_cfg[0] = 32'hA0A0_0001;
        rdata_cfg[1] = 32'h1234_5678;
        rdata_cfg[2] = 32'h2222_BEEF;
        for (int k = 0; k < TGT_N; k++) wait_cfg[k] = 0;

        //          addr           wr  wdata          strb   wt  terr sel     paddr          rdata          err lat
        vecs[0] = '{32'h8000_0004, 0, 32'h0,         4'h0,  0,  0,  3'b010, 32'h0000_0004, 32'h1234_5678, 0, 3};
        vecs[1] = '{32'h9000_0010, 1, 32'hDEAD_BEEF, 4'h3,  3,  0,  3'b100, 32'h0000_0010, 32'h2222_BEEF, 0, 6};
        vecs[2] = '{32'h8000_1000, 0, 32'h0,         4'h0,  0,  0,  3'b000, 32'h0,         32'h0,         1, 1};
        vecs[3] = '{32'h0000_0100, 0, 32'h0,         4'h0,  1,  1,  3'b001, 32'h0000_0100, 32'hA0A0_0001, 1, 4};
        vecs[4] = '{32'h7FFF_FFFC, 1, 32'h5555_AAAA, 4'hF,  0,  0,  3'b001, 32'h7FFF_FFFC, 32'hA0A0_0001, 0, 3};
        vecs[5] = '{32'h93FF_FFFC, 0, 32'h0,         4'h0,  2,  0,  3'b100, 32'h03FF_FFFC, 32'h2222_BEEF, 0, 5};
        vecs[6] = '{32'h8000_0FFC, 0, 32'h0,         4'h0,  0,  1,  3'b010, 32'h0000_0FFC, 32'h1234_5678, 1, 3};
        vecs[7] = '{32'h9400_0000, 0, 32'h0,         4'h0,  0,  0,  3'b000, 32'h0,         32'h0,         1, 1};
        vecs[8] = '{32'hFFFF_FFFF, 1, 32'h1111_2222, 4'h1,  0,  0,  3'b000, 32'h0,         32'h0,         1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven transfers
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
            idle_check();
        end

        // Back-to-back: i_psel held high in the cycle after RESP
        run_vec(vecs[0]);
        run_vec(vecs[5]);
        idle_check();

        // pready raised during T_SETUP must be ignored
        setup_rdy = 3'b010;
        v = vecs[0];
        v.wt = 1; v.exp_lat = 4;
        run_vec(v);
        setup_rdy = '0;
        idle_check();

`ifdef APB_SPLITTER_TIMEOUT_EN
        // Hung target aborted after 8 access cycles
        v = vecs[1];
        v.write = 0; v.wdata = 32'h0; v.strb = 4'h0;
        v.wt = NEVER; v.exp_rdata = 32'h0; v.exp_err = 1; v.exp_lat = 10;
        run_vec(v);
        idle_check();
        run_vec(vecs[0]);
        idle_check();
`endif

        // Reset during T_ACCESS with a hung target
        for (int k = 0; k < TGT_N; k++) wait_cfg[k] = NEVER;
        err_cfg = '0;
        i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1;
        i_paddr = 32'h9000_0010; i_pwdata = 32'hCAFE_F00D; i_pwstrb = 4'hF;
        @(posedge clk); #1; i_penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_t_penable", t_penable, 1);
        chk("pre_reset_t_psel", t_psel, 3'b100);
        chk("pre_reset_i_prdata", i_prdata, last_rdata);
`ifndef APB_SPLITTER_TIMEOUT_EN
        repeat (20) @(negedge clk);
        chk("hung_wait_t_psel", t_psel, 3'b100);
        chk("hung_wait_i_pready", i_pready, 0);
`endif
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        $display("[TB] reset asserted mid-transfer");
        i_psel = 1'b0; i_penable = 1'b0;
        @(negedge clk);
        check_all_zero("held_reset");
        rst_n = 1'b1;
        last_rdata = '0;
        @(posedge clk); #1;
        run_vec(vecs[0]);
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
